// File: rtl/spi_display_rx_if.sv
// Consumer-side stream of received display bytes: head-of-FIFO byte, its D/C tag,
// and the valid/ready handshake.
interface spi_display_rx_if;
    logic [7:0] RxData;
    logic       RxDnC;
    logic       RxValid;
    logic       RxReady;

    modport master (output RxData, output RxDnC, output RxValid, input RxReady);
    modport slave  (input RxData, input RxDnC, input RxValid, output RxReady);
endinterface

// File: rtl/spi_display_rx.sv
// Write-only OLED SPI receiver: synchronises the pins into Clock, deserialises
// MSB-first bytes tagged with DnC, and queues them in a small FWFT FIFO.
module spi_display_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               SCLK,
    input  logic               nCS,
    input  logic               DnC,
    input  logic               SDIN,
    input  logic               ClearErr,
    output logic               Overflow,
    output logic               FrameErr,
    output logic [CNT_W-1:0]   ByteCount,
    spi_display_rx_if.master   rx
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ncs_meta_q, ncs_sync_q;
    logic dnc_meta_q, dnc_sync_q;
    logic sdin_meta_q, sdin_sync_q;

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_dnc_q, rx_dnc_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic       rise_s, push_s, frame_set_s;
    logic       empty_s, full_s, pop_s, push_ok_s, drop_s;
    logic [8:0] push_word_s;

    // Deserialiser: byte completion and frame-error detection from synchronised pins.
    always_comb begin
        rise_s      = sclk_sync_q & ~sclk_prev_q;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        push_word_s = {dnc_sync_q, shreg_q, sdin_sync_q};
        case (state_q)
            ST_IDLE: begin
                bitcnt_d = 3'd0;
                if (!ncs_sync_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Deselect wins over a coincident clock edge; a partial byte is dropped.
                if (ncs_sync_q) begin
                    state_d     = ST_IDLE;
                    bitcnt_d    = 3'd0;
                    frame_set_s = (bitcnt_q != 3'd0);
                end else if (rise_s) begin
                    shreg_d  = {shreg_q[5:0], sdin_sync_q};
                    bitcnt_d = bitcnt_q + 3'd1;
                    push_s   = (bitcnt_q == 3'd7);
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = 3'd0;
            end
        endcase
    end

    // FWFT FIFO, sticky flags and the accepted-byte counter.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s     = ~empty_s & rx.RxReady;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_ok_s = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;

        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_word_s;
        end else begin
            mem_d = mem_q;
        end

        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok_s};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
        rx_valid_d = (wr_ptr_d != rd_ptr_d);
        if (rx_valid_d) begin
            {rx_dnc_d, rx_data_d} = mem_d[rd_ptr_d[AW-1:0]];
        end else begin
            rx_dnc_d  = rx_dnc_q;
            rx_data_d = rx_data_q;
        end

        overflow_d  = (overflow_q & ~ClearErr) | drop_s;
        frame_err_d = (frame_err_q & ~ClearErr) | frame_set_s;
        byte_cnt_d  = byte_cnt_q + {{(CNT_W-1){1'b0}}, push_ok_s};
    end

    // Pin synchronisers plus all receiver and FIFO state.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            ncs_meta_q  <= 1'b1;
            ncs_sync_q  <= 1'b1;
            dnc_meta_q  <= 1'b0;
            dnc_sync_q  <= 1'b0;
            sdin_meta_q <= 1'b0;
            sdin_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 7'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rx_data_q   <= 8'd0;
            rx_dnc_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ncs_meta_q  <= nCS;
            ncs_sync_q  <= ncs_meta_q;
            dnc_meta_q  <= DnC;
            dnc_sync_q  <= dnc_meta_q;
            sdin_meta_q <= SDIN;
            sdin_sync_q <= sdin_meta_q;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_data_q   <= rx_data_d;
            rx_dnc_q    <= rx_dnc_d;
            rx_valid_q  <= rx_valid_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign rx.RxData  = rx_data_q;
    assign rx.RxDnC   = rx_dnc_q;
    assign rx.RxValid = rx_valid_q;
    assign Overflow   = overflow_q;
    assign FrameErr   = frame_err_q;
    assign ByteCount  = byte_cnt_q;
endmodule

// File: tb/tb_spi_display_rx.sv
// Bench for spi_display_rx: bit-banged SPI frames against a queue-based model of
// the receive FIFO, byte counter and sticky flags.
module tb_spi_display_rx;
    localparam int DEPTH = 4;
    // Narrow counter so the wrap is reachable in a short run.
    localparam int CNT_W = 4;
    localparam int CNT_MASK = (1 << CNT_W) - 1;

    logic Clock = 1'b0, nReset = 1'b0, SCLK = 1'b0, nCS = 1'b1;
    logic DnC = 1'b0, SDIN = 1'b0, ClearErr = 1'b0;
    logic Overflow, FrameErr;
    logic [CNT_W-1:0] ByteCount;
    logic rand_mode = 1'b0, ready_man = 1'b0, ready_rnd = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];
    int model_cnt = 0;
    logic model_ovf = 1'b0;
    logic model_ferr = 1'b0;

    spi_display_rx_if rx_if ();
    assign rx_if.RxReady = rand_mode ? ready_rnd : ready_man;

    spi_display_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .nReset(nReset), .SCLK(SCLK), .nCS(nCS), .DnC(DnC),
        .SDIN(SDIN), .ClearErr(ClearErr), .Overflow(Overflow),
        .FrameErr(FrameErr), .ByteCount(ByteCount), .rx(rx_if.master)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) ready_rnd <= 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted handshake must deliver the oldest modelled byte.
    always @(negedge Clock) begin
        if (nReset && rx_if.RxValid && rx_if.RxReady) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop", 32'd1, 32'd0);
            end else begin
                check("rx_word", {23'd0, rx_if.RxDnC, rx_if.RxData}, {23'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic model_push(input logic [7:0] b, input logic d, input bit pop_same);
        if (exp_q.size() < DEPTH || pop_same) begin
            exp_q.push_back({d, b});
            model_cnt++;
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    // Shift out nbits of b MSB first; pulse pops the FIFO exactly when the 8th bit pushes.
    task automatic send_bits(input logic [7:0] b, input int nbits, input int half, input bit pulse);
        for (int i = 0; i < nbits; i++) begin
            SDIN = b[7-i];
            tick(half);
            SCLK = 1'b1;
            if (i == 7) model_push(b, DnC, pulse);
            for (int k = 1; k <= half; k++) begin
                tick(1);
                if (pulse && i == 7) begin
                    if (k == 2) ready_man = 1'b1;
                    else if (k == 3) ready_man = 1'b0;
                end
            end
            SCLK = 1'b0;
        end
    endtask

    task automatic frame_begin(input logic d);
        DnC = d;
        nCS = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        nCS = 1'b1;
        tick(5);
    endtask

    task automatic drain();
        ready_man = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick(1);
        check("drain_empty", exp_q.size(), 32'd0);
        tick(2);
        check("drain_valid_low", rx_if.RxValid, 1'b0);
        ready_man = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] rb;
        tick(3);
        check("rst_valid", rx_if.RxValid, 1'b0);
        check("rst_data", rx_if.RxData, 8'h00);
        check("rst_dnc", rx_if.RxDnC, 1'b0);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_ferr", FrameErr, 1'b0);
        check("rst_cnt", ByteCount, 0);
        nReset = 1'b1;
        tick(3);

        // Command byte then data byte in one frame.
        ready_man = 1'b1;
        frame_begin(1'b0);
        send_bits(8'hAE, 8, 2, 1'b0);
        DnC = 1'b1;
        send_bits(8'h5A, 8, 2, 1'b0);
        frame_end();
        drain();
        check("cmd_data_cnt", ByteCount, 2);
        check("cmd_data_ferr", FrameErr, 1'b0);

        // Latency at SCLK = Clock/4 into an empty FIFO.
        frame_begin(1'b1);
        send_bits(8'h81, 7, 2, 1'b0);
        SDIN = 1'b1;
        tick(2);
        SCLK = 1'b1;
        model_push(8'h81, 1'b1, 1'b0);
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (rx_if.RxValid && lat < 0) lat = k;
        end
        SCLK = 1'b0;
        check("latency_le4", (lat >= 1 && lat <= 4), 1'b1);
        check("latency_data", rx_if.RxData, 8'h81);
        frame_end();
        drain();

        // Overflow, clear, then a push coinciding with a pop on a full FIFO.
        frame_begin(1'b1);
        for (int v = 1; v <= 5; v++) send_bits(8'(v), 8, 2, 1'b0);
        tick(4);
        check("ovf_set", Overflow, model_ovf);
        check("ovf_cnt", ByteCount, model_cnt & CNT_MASK);
        check("ovf_head", rx_if.RxData, 8'h01);
        ClearErr = 1'b1;
        tick(1);
        ClearErr = 1'b0;
        model_ovf = 1'b0;
        check("ovf_cleared", Overflow, 1'b0);
        send_bits(8'h05, 8, 4, 1'b1);
        tick(4);
        check("ovf_pop_push", Overflow, model_ovf);
        frame_end();
        drain();
        check("ovf_final_cnt", ByteCount, model_cnt & CNT_MASK);

        // Frame error, recovery, and set-beats-clear.
        frame_begin(1'b1);
        send_bits(8'hA0, 3, 2, 1'b0);
        frame_end();
        model_ferr = 1'b1;
        check("ferr_set", FrameErr, model_ferr);
        check("ferr_no_push", rx_if.RxValid, 1'b0);
        check("ferr_cnt", ByteCount, model_cnt & CNT_MASK);
        ClearErr = 1'b1;
        tick(1);
        ClearErr = 1'b0;
        check("ferr_cleared", FrameErr, 1'b0);
        frame_begin(1'b1);
        send_bits(8'h3C, 8, 2, 1'b0);
        frame_end();
        drain();
        check("ferr_recover", FrameErr, 1'b0);
        frame_begin(1'b0);
        send_bits(8'hFF, 5, 2, 1'b0);
        tick(2);
        nCS = 1'b1;
        tick(2);
        ClearErr = 1'b1;
        tick(1);
        ClearErr = 1'b0;
        tick(3);
        check("ferr_set_wins", FrameErr, 1'b1);
        ClearErr = 1'b1;
        tick(1);
        ClearErr = 1'b0;

        // Asynchronous reset mid-byte with two bytes queued.
        frame_begin(1'b1);
        send_bits(8'h11, 8, 2, 1'b0);
        send_bits(8'h22, 8, 2, 1'b0);
        send_bits(8'h55, 5, 2, 1'b0);
        #3;
        nReset = 1'b0;
        #1;
        check("arst_valid", rx_if.RxValid, 1'b0);
        check("arst_data", rx_if.RxData, 8'h00);
        check("arst_cnt", ByteCount, 0);
        check("arst_ovf", Overflow, 1'b0);
        exp_q.delete();
        model_cnt = 0;
        nCS = 1'b1;
        tick(3);
        nReset = 1'b1;
        tick(3);
        check("arst_no_ferr", FrameErr, 1'b0);
        frame_begin(1'b1);
        send_bits(8'hF0, 8, 2, 1'b0);
        frame_end();
        check("arst_first", rx_if.RxData, 8'hF0);
        check("arst_cnt1", ByteCount, 1);
        drain();

        // SCLK activity while deselected is ignored.
        for (int g = 0; g < 10; g++) begin
            SDIN = 1'($urandom_range(0, 1));
            tick(2);
            SCLK = 1'b1;
            tick(2);
            SCLK = 0;
        end
        tick(5);
        check("idle_cnt", ByteCount, model_cnt & CNT_MASK);
        check("idle_valid", rx_if.RxValid, 1'b0);

        // Randomised bytes and tags against a randomly stalling consumer.
        rand_mode = 1'b1;
        frame_begin(1'b0);
        for (int n = 0; n < 24; n++) begin
            DnC = 1'($urandom_range(0, 1));
            for (int t = 0; t < 200 && exp_q.size() >= DEPTH; t++) tick(1);
            check("rand_space", exp_q.size() < DEPTH, 1'b1);
            rb = 8'($urandom);
            send_bits(rb, 8, $urandom_range(2, 3), 1'b0);
        end
        frame_end();
        rand_mode = 1'b0;
        drain();
        check("rand_ovf", Overflow, model_ovf);
        check("rand_cnt", ByteCount, model_cnt & CNT_MASK);

        // Counter wrap: fill to all-ones, then one more byte.
        ready_man = 1'b1;
        frame_begin(1'b1);
        while ((model_cnt & CNT_MASK) != CNT_MASK) send_bits(8'($urandom), 8, 2, 1'b0);
        tick(5);
        check("wrap_max", ByteCount, CNT_MASK);
        send_bits(8'hC3, 8, 2, 1'b0);
        tick(5);
        check("wrap_zero", ByteCount, 0);
        frame_end();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
